// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmit/receive paths.
// Frame length depends on SERIAL_TX_PARITY_EN (even-parity bit between data and stop).
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Bits per frame: start + data + (parity) + stop.
    function automatic int unsigned frame_bits(input int unsigned data_w);
`ifdef SERIAL_TX_PARITY_EN
        return data_w + 3;
`else
        return data_w + 2;
`endif
    endfunction

endpackage

// File: rtl/serial_baud_tick.sv
// Bit-period counter: one-cycle tick on the last clock of each bit, held at 0 while clr is high.
// Shared with the receive side.
module serial_baud_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    // Gated by clr so CLKS_PER_BIT=1 does not tick while idle.
    assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/serial_tx.sv
// UART-style transmitter: start bit, DATA_W bits LSB-first, optional even parity, stop bit.
// Define SERIAL_TX_PARITY_EN to insert the parity bit.
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    output logic              ready,
    output logic              tx,
    output logic              busy
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_t            state;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_nxt;
    logic              tick;
    logic              accept;
`ifdef SERIAL_TX_PARITY_EN
    logic              par_q;
`endif

    assign ready     = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = valid && ready;
    assign shift_nxt = shift_reg >> 1;

    serial_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE),
        .tick (tick)
    );

    // tx is loaded with the level of the bit about to start, so the pin
    // changes on the same edge as the state and never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= IDLE_LEVEL;
            bit_cnt   <= '0;
            shift_reg <= '0;
`ifdef SERIAL_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state     <= START;
                    tx        <= START_LEVEL;
                    shift_reg <= data;
                    bit_cnt   <= '0;
`ifdef SERIAL_TX_PARITY_EN
                    par_q     <= ^data;
`endif
                end
                START: if (tick) begin
                    state <= DATA;
                    tx    <= shift_reg[0];
                end
                DATA: if (tick) begin
                    shift_reg <= shift_nxt;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
                        state   <= PARITY;
                        tx      <= par_q;
`else
                        state   <= STOP;
                        tx      <= STOP_LEVEL;
`endif
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                        tx      <= shift_nxt[0];
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PARITY: if (tick) begin
                    state <= STOP;
                    tx    <= STOP_LEVEL;
                end
`endif
                STOP: if (tick) begin
                    state <= IDLE;
                    tx    <= IDLE_LEVEL;
                end
                default: begin
                    state <= IDLE;
                    tx    <= IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule
